// File: rtl/irq_pending_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : irq_pending_ctrl
// Purpose  : Synchronises eight request lines, latches rising edges as pending,
//            presents masked pending to the priority encoder and clears on ack.
// Revision : 1.0 - initial release
// ============================================================================
module irq_pending_ctrl (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] irq_in,
   input  logic [7:0] mask,
   input  logic       enable,
   output logic [7:0] d,
   output logic       en,
   input  logic [2:0] svc_code,
   input  logic       svc_ack,
   output logic       busy,
   output logic [7:0] ovf,
   input  logic       ovf_clr
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_REQ   = 2'd1;
   localparam logic [1:0] S_CLEAR = 2'd2;

   logic [7:0] s1_q, s2_q, s3_q;
   logic [7:0] pend_q, pend_d;
   logic [7:0] ovf_q, ovf_d;
   logic [1:0] state_q, state_d;
   logic       en_q, en_d;
   logic       busy_q, busy_d;
   logic [7:0] w_edge;
   logic [7:0] w_clr;
   logic       w_ack_hit;
   logic [2:0] w_svc_bit;

   // Code 0 is bit 7, so the serviced bit index is 7 - code, i.e. ~code.
   assign w_svc_bit = ~svc_code;
   assign w_edge    = s2_q & ~s3_q;
   assign w_ack_hit = (state_q == S_REQ) && enable && svc_ack && pend_q[w_svc_bit];
   assign w_clr     = w_ack_hit ? (8'd1 << w_svc_bit) : 8'd0;

   assign d    = pend_q & mask;
   assign en   = en_q;
   assign busy = busy_q;
   assign ovf  = ovf_q;

   // An edge arriving on a bit being cleared re-sets it and is not an overflow.
   always_comb begin
      pend_d = (pend_q & ~w_clr) | w_edge;
      ovf_d  = (ovf_q & ~{8{ovf_clr}}) | (w_edge & pend_q & ~w_clr);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q    <= 8'd0;
         s2_q    <= 8'd0;
         s3_q    <= 8'd0;
         pend_q  <= 8'd0;
         ovf_q   <= 8'd0;
         state_q <= S_IDLE;
         en_q    <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         s1_q    <= irq_in;
         s2_q    <= s1_q;
         s3_q    <= s2_q;
         pend_q  <= pend_d;
         ovf_q   <= ovf_d;
         state_q <= state_d;
         en_q    <= en_d;
         busy_q  <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (!enable) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:  if (d != 8'd0) state_d = S_REQ;
            S_REQ: begin
               if (w_ack_hit)        state_d = S_CLEAR;
               else if (d == 8'd0)   state_d = S_IDLE;
            end
            S_CLEAR: state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Outputs are registered alongside the state they decode.
   always_comb begin
      en_d   = (state_d == S_REQ);
      busy_d = (state_d == S_REQ) || (state_d == S_CLEAR);
   end

endmodule
`default_nettype wire

// File: tb/tb_irq_pending_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_pending_ctrl
// Purpose  : Directed vector table, corner sequences and random run against a
//            cycle-level reference model of irq_pending_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_irq_pending_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] irq_in, mask, d, ovf;
   logic       enable, en, svc_ack, busy, ovf_clr;
   logic [2:0] svc_code;

   int n_vec = 0;
   int n_err = 0;

   irq_pending_ctrl dut (
      .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .mask(mask), .enable(enable),
      .d(d), .en(en), .svc_code(svc_code), .svc_ack(svc_ack), .busy(busy),
      .ovf(ovf), .ovf_clr(ovf_clr)
   );

   always #5 clk = ~clk;

   // Reference model: sync history per line, pending/overflow sets, phase 0/1/2
   bit [7:0] m_hist [3];
   bit [7:0] m_pend, m_ovf;
   int       m_phase;   // 0 idle, 1 requesting, 2 clearing bubble

   task automatic model_reset();
      for (int i = 0; i < 3; i++) m_hist[i] = 8'd0;
      m_pend  = 8'd0;
      m_ovf   = 8'd0;
      m_phase = 0;
   endtask

   task automatic model_step();
      bit [7:0] rising, cleared, vis;
      int       idx;
      bit       accepted;
      rising   = m_hist[1] & ~m_hist[2];
      idx      = 7 - int'(svc_code);
      accepted = (m_phase == 1) && enable && svc_ack && m_pend[idx];
      cleared  = accepted ? 8'(1 << idx) : 8'd0;
      vis      = m_pend & mask;
      if (!enable)           m_phase = 0;
      else if (m_phase == 0) m_phase = (vis != 0) ? 1 : 0;
      else if (m_phase == 1) m_phase = accepted ? 2 : ((vis == 0) ? 0 : 1);
      else                   m_phase = 0;
      for (int i = 0; i < 8; i++) begin
         if (ovf_clr) m_ovf[i] = 1'b0;
         if (rising[i] && m_pend[i] && !cleared[i]) m_ovf[i] = 1'b1;
         if (cleared[i]) m_pend[i] = 1'b0;
         if (rising[i])  m_pend[i] = 1'b1;
      end
      m_hist[2] = m_hist[1];
      m_hist[1] = m_hist[0];
      m_hist[0] = irq_in;
   endtask

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      chk("model_d",    d,           m_pend & mask);
      chk("model_en",   {7'd0, en},   {7'd0, m_phase == 1});
      chk("model_busy", {7'd0, busy}, {7'd0, m_phase != 0});
      chk("model_ovf",  ovf,         m_ovf);
   endtask

   // One clock: model and DUT both see the inputs driven before the edge.
   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      check_model();
   endtask

   task automatic drive(input logic [7:0] irq, input logic [2:0] code, input logic ack);
      irq_in   = irq;
      svc_code = code;
      svc_ack  = ack;
   endtask

   typedef struct {
      logic [7:0] irq;
      logic [2:0] code;
      logic       ack;
      logic [7:0] exp_d;
      logic       exp_en;
      logic       exp_busy;
   } vec_t;

   vec_t tbl [15];

   initial begin
      tbl[0]  = '{8'h20, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0};
      tbl[1]  = '{8'h20, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0};
      tbl[2]  = '{8'h00, 3'd0, 1'b0, 8'h20, 1'b0, 1'b0};
      tbl[3]  = '{8'h00, 3'd0, 1'b0, 8'h20, 1'b1, 1'b1};
      tbl[4]  = '{8'h00, 3'd2, 1'b1, 8'h00, 1'b0, 1'b1};
      tbl[5]  = '{8'h00, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0};
      tbl[6]  = '{8'h81, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0};
      tbl[7]  = '{8'h81, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0};
      tbl[8]  = '{8'h00, 3'd0, 1'b0, 8'h81, 1'b0, 1'b0};
      tbl[9]  = '{8'h00, 3'd0, 1'b0, 8'h81, 1'b1, 1'b1};
      tbl[10] = '{8'h00, 3'd0, 1'b1, 8'h01, 1'b0, 1'b1};
      tbl[11] = '{8'h00, 3'd0, 1'b0, 8'h01, 1'b0, 1'b0};
      tbl[12] = '{8'h00, 3'd0, 1'b0, 8'h01, 1'b1, 1'b1};
      tbl[13] = '{8'h00, 3'd7, 1'b1, 8'h00, 1'b0, 1'b1};
      tbl[14] = '{8'h00, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0};

      rst_n = 1'b0; mask = 8'hFF; enable = 1'b1; ovf_clr = 1'b0;
      drive(8'h00, 3'd0, 1'b0);
      model_reset();
      #2;
      chk("reset_d", d, 8'h00);
      chk("reset_en_busy", {6'd0, en, busy}, 8'h00);
      chk("reset_ovf", ovf, 8'h00);
      #10 rst_n = 1'b1;

      // Test-plan sequences 1 and 2
      for (int i = 0; i < 15; i++) begin
         drive(tbl[i].irq, tbl[i].code, tbl[i].ack);
         cycle();
         chk($sformatf("tbl%0d_d", i), d, tbl[i].exp_d);
         chk($sformatf("tbl%0d_en", i), {7'd0, en}, {7'd0, tbl[i].exp_en});
         chk($sformatf("tbl%0d_busy", i), {7'd0, busy}, {7'd0, tbl[i].exp_busy});
      end

      // Overflow on line 3: two separate edges, hold off service with enable=0
      enable = 1'b0;
      for (int k = 0; k < 2; k++) begin
         drive(8'h08, 3'd0, 1'b0); cycle(); cycle();
         drive(8'h00, 3'd0, 1'b0); cycle(); cycle();
      end
      chk("ovf_set", ovf, 8'h08);
      chk("ovf_pend", d, 8'h08);
      ovf_clr = 1'b1; cycle(); ovf_clr = 1'b0;
      chk("ovf_clr", ovf, 8'h00);

      // Edge on line 3 lands on the same edge as its ack: set wins, no overflow
      enable = 1'b1;
      cycle();
      chk("req_line3", {7'd0, en}, 8'h01);
      drive(8'h08, 3'd0, 1'b0); cycle(); cycle();
      drive(8'h00, 3'd4, 1'b1); cycle();
      drive(8'h00, 3'd0, 1'b0);
      chk("set_wins_d", d, 8'h08);
      chk("set_wins_ovf", ovf, 8'h00);
      cycle(); cycle();
      drive(8'h00, 3'd4, 1'b1); cycle();
      drive(8'h00, 3'd0, 1'b0); cycle(); cycle();
      chk("line3_done", d, 8'h00);

      // Masking: pending 0x10 hidden, then shown, then non-pending ack ignored
      mask = 8'h00;
      drive(8'h10, 3'd0, 1'b0); cycle(); cycle();
      drive(8'h00, 3'd0, 1'b0); cycle(); cycle();
      chk("masked_d", d, 8'h00);
      chk("masked_en", {7'd0, en}, 8'h00);
      mask = 8'h10; cycle();
      chk("unmask_en", {7'd0, en}, 8'h01);
      drive(8'h00, 3'd6, 1'b1); cycle();
      drive(8'h00, 3'd0, 1'b0);
      chk("bad_ack_en", {7'd0, en}, 8'h01);
      chk("bad_ack_d", d, 8'h10);
      mask = 8'h00; cycle();
      chk("remask_en", {7'd0, en}, 8'h00);
      chk("remask_busy", {7'd0, busy}, 8'h00);

      // Disabled with pending 0x04 visible on d only
      mask = 8'hFF; enable = 1'b0;
      drive(8'h04, 3'd0, 1'b0); cycle(); cycle();
      drive(8'h00, 3'd0, 1'b0); cycle(); cycle();
      chk("dis_d", d, 8'h14);
      chk("dis_en_busy", {6'd0, en, busy}, 8'h00);

      // Async reset in REQ
      enable = 1'b1; cycle(); cycle();
      chk("pre_rst_en", {7'd0, en}, 8'h01);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_en", {7'd0, en}, 8'h00);
      chk("async_rst_busy", {7'd0, busy}, 8'h00);
      chk("async_rst_d", d, 8'h00);
      model_reset();
      #3 rst_n = 1'b1;

      // Random run against the model
      for (int n = 0; n < 1500; n++) begin
         logic [7:0] irq_nxt;
         irq_nxt = irq_in;
         if ($urandom_range(0, 3) == 0) irq_nxt[$urandom_range(0, 7)] ^= 1'b1;
         drive(irq_nxt, 3'($urandom_range(0, 7)), ($urandom_range(0, 9) < 4));
         if ($urandom_range(0, 19) == 0) mask = 8'($urandom);
         else if ($urandom_range(0, 19) == 0) mask = 8'hFF;
         enable  = ($urandom_range(0, 9) != 0);
         ovf_clr = ($urandom_range(0, 19) == 0);
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
